// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM controller: FSM state encoding,
// default opcodes and bit-counter width.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ_DEF  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
  localparam int unsigned BIT_CNT_W    = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with single-cycle
// rise/fall pulses derived from the synchronized level.
//   i_clk   system clock
//   i_rst   synchronous active-high reset (flops load RST_VAL)
//   i_d     asynchronous input
//   o_q     synchronized level
//   o_rise  one-cycle pulse on synchronized 0->1
//   o_fall  one-cycle pulse on synchronized 1->0
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic ff0, ff1, prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ff0  <= RST_VAL;
      ff1  <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      ff0  <= i_d;
      ff1  <= ff0;
      prev <= ff1;
    end
  end

  assign o_q    = ff1;
  assign o_rise = ff1 & ~prev;
  assign o_fall = ~ff1 & prev;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI mode-0 slave that turns READ/WRITE frames into byte-wide RAM strobes.
// Frame: opcode, address high byte, address low byte, then data bytes with
// address auto-increment. Reads prefetch the next byte after each byte.
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_sclk/i_cs_n/i_mosi asynchronous SPI pins
//   o_miso              read data out, 0 outside the read data phase
//   o_addr/o_wdata      RAM byte address / write data
//   o_we/o_re           one-cycle RAM strobes
//   i_rdata             RAM read data, valid RD_LAT cycles after o_re
//   o_active            high while a frame is being handled
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sclk,
  input  logic          i_cs_n,
  input  logic          i_mosi,
  output logic          o_miso,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_wdata,
  output logic          o_we,
  output logic          o_re,
  input  logic [7:0]    i_rdata,
  output logic          o_active
);

  state_t state, state_nxt;

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_ff0, mosi_s;

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           rx_sr, tx_sr, addr_hi, rx_byte;
  logic [AW-1:0]        addr;
  logic [15:0]          addr_full;
  logic                 cmd_rd;
  logic [RD_LAT-1:0]    rd_pipe;
  logic [RD_LAT:0]      rd_pipe_in;

  logic in_frame, shift_en, byte_done, re_nxt, we_nxt;

  // Only SCLK edges matter; its synchronized level is not used.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_sclk),
    .o_q    (sclk_lvl_unused),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  // CS_n idles high, so reset the synchronizer high to avoid a false edge.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_cs_n),
    .o_q    (cs_s),
    .o_rise (cs_rise),
    .o_fall (cs_fall)
  );

  // Same two-stage delay as SCLK, keeping MOSI aligned with sclk_rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mosi_ff0 <= 1'b0;
      mosi_s   <= 1'b0;
    end else begin
      mosi_ff0 <= i_mosi;
      mosi_s   <= mosi_ff0;
    end
  end

  assign rx_byte    = {rx_sr[6:0], mosi_s};
  assign addr_full  = {addr_hi, rx_byte};
  assign rd_pipe_in = {rd_pipe, o_re};
  assign in_frame   = state inside {CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA};
  assign shift_en   = sclk_rise & ~cs_s & in_frame;
  assign byte_done  = shift_en & (bit_cnt == '1);

  always_comb begin
    state_nxt = state;
    re_nxt    = 1'b0;
    we_nxt    = 1'b0;
    case (state)
      IDLE:    if (cs_fall) state_nxt = CMD;
      CMD:     if (byte_done)
                 state_nxt = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? ADDR_HI : IGNORE;
      ADDR_HI: if (byte_done) state_nxt = ADDR_LO;
      ADDR_LO: if (byte_done) begin
                 state_nxt = cmd_rd ? RD_DATA : WR_DATA;
                 re_nxt    = cmd_rd;
               end
      RD_DATA: re_nxt = byte_done;
      WR_DATA: we_nxt = byte_done;
      default: state_nxt = state;
    endcase
    // CS release ends the frame from any state; an unfinished byte is dropped.
    if (cs_rise) begin
      state_nxt = IDLE;
      re_nxt    = 1'b0;
      we_nxt    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      addr_hi <= '0;
      addr    <= '0;
      cmd_rd  <= 1'b0;
      rd_pipe <= '0;
      o_wdata <= '0;
      o_we    <= 1'b0;
      o_re    <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_re    <= re_nxt;
      o_we    <= we_nxt;
      rd_pipe <= rd_pipe_in[RD_LAT-1:0];

      if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        rx_sr   <= rx_byte;
      end

      if (state == CMD && byte_done) cmd_rd <= (rx_byte == CMD_READ);
      if (state == ADDR_HI && byte_done) addr_hi <= rx_byte;
      if (we_nxt) o_wdata <= rx_byte;

      // Reads advance with the prefetch strobe; writes advance the cycle
      // after their strobe so o_addr holds the written address during o_we.
      if (state == ADDR_LO && byte_done)
        addr <= addr_full[AW-1:0];
      else if ((state == RD_DATA && byte_done) || o_we)
        addr <= addr + AW'(1);

      // Shifting is held while bit_cnt is 0 so the falling edge that follows
      // a byte boundary keeps the freshly loaded bit 7 on MISO.
      if (state == ADDR_LO && byte_done)
        tx_sr <= '0;
      else if (state == RD_DATA) begin
        if (rd_pipe_in[RD_LAT])
          tx_sr <= i_rdata;
        else if (sclk_fall && !cs_s && bit_cnt != '0)
          tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  assign o_addr   = addr;
  assign o_miso   = (state == RD_DATA) & tx_sr[7];
  assign o_active = (state != IDLE);

endmodule
